// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared FSM encodings, master IDs and wait-counter width helper for dm_arbiter.
package dm_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOCK0 = 2'd1, ST_LOCK1 = 2'd2} state_e;
  localparam logic MST0 = 1'b0;
  localparam logic MST1 = 1'b1;
  function automatic int wait_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/dm_arb_starve_cnt.sv
// dm_arb_starve_cnt: saturating count of consecutive denied m1 cycles; sat_o flags the override point.
module dm_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);
  import dm_arb_pkg::*;
  localparam int W = wait_w(STARVE_LIMIT);
  logic [W-1:0] cnt_q, cnt_d;
  assign sat_o = cnt_q == W'(STARVE_LIMIT);
  always_comb cnt_d = clr_i ? '0 : (inc_i && !sat_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master data-memory arbiter, m0 priority, m1 starvation override, bounded lock tenure.
// Define ARB_TRACE_EN to print every granted write in the memory trace format.
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_LOCK     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_pc,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_pc,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  output logic        dm_we,
  input  logic [31:0] dm_rdata
);
  import dm_arb_pkg::*;
  localparam int LW = $clog2(MAX_LOCK + 1);
  state_e        state_q;
  logic [LW-1:0] lock_cnt_q;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic [31:0]   m0_rdata_q, m1_rdata_q;
  logic          sat, any, sel, lock, last;
  dm_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (reset),
    .inc_i (m1_req && !m1_gnt),
    .clr_i (!m1_req || m1_gnt),
    .sat_o (sat)
  );
  // The starvation override is only honoured in ST_IDLE; a lock owner is never preempted.
  always_comb begin
    m0_gnt   = !reset && m0_req && (state_q == ST_LOCK0 || (state_q == ST_IDLE && !(m1_req && sat)));
    m1_gnt   = !reset && m1_req && (state_q == ST_LOCK1 || (state_q == ST_IDLE && (sat || !m0_req)));
    any      = m0_gnt || m1_gnt;
    sel      = m1_gnt ? MST1 : MST0;
    lock     = (sel == MST1) ? m1_lock : m0_lock;
    last     = lock_cnt_q == LW'(MAX_LOCK - 1);
    dm_addr  = !any ? '0 : (sel == MST1) ? m1_addr : m0_addr;
    dm_wdata = !any ? '0 : (sel == MST1) ? m1_wdata : m0_wdata;
    dm_pc    = !any ? '0 : (sel == MST1) ? m1_pc : m0_pc;
    dm_we    = any && ((sel == MST1) ? m1_we : m0_we);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lock_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_gnt && !m0_we;
      m1_rvalid_q <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata_q <= dm_rdata;
      if (m1_gnt && !m1_we) m1_rdata_q <= dm_rdata;
      if (state_q == ST_IDLE) begin
        if (any && lock && MAX_LOCK > 1) begin
          state_q    <= (sel == MST1) ? ST_LOCK1 : ST_LOCK0;
          lock_cnt_q <= LW'(1);
        end
      end else if (!any || !lock || last) begin
        state_q    <= ST_IDLE;
        lock_cnt_q <= '0;
      end else begin
        lock_cnt_q <= lock_cnt_q + 1'b1;
      end
    end
  end
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
`ifdef ARB_TRACE_EN
  always_ff @(posedge clk)
    if (dm_we) $display("%s%d@%h: *%h <= %h", m1_gnt ? "M1 " : "M0 ", $time, dm_pc, dm_addr, dm_wdata);
`else
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed test-plan scenarios then random traffic, checked against an owner/tenure model.
module tb_dm_arbiter;
  localparam int SL = 4;
  localparam int ML = 3;
  logic        clk = 1'b0, reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, m1_pc;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, dm_we;
  logic [31:0] m0_rdata, m1_rdata, dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  int          n_vec = 0, n_err = 0;
  int          owner = -1, tenure = 0, waited = 0;
  logic        exp_rv0 = 0, exp_rv1 = 0, pend0 = 0, pend1 = 0, last_g1 = 0;
  logic [31:0] exp_rd0 = 0, exp_rd1 = 0;

  dm_arbiter #(.STARVE_LIMIT(SL), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc), .dm_we(dm_we), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;
  assign dm_rdata = mem[dm_addr[5:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[5:2]] <= dm_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Inputs are set at a falling edge; this checks the cycle and advances to the next falling edge.
  task automatic step();
    logic e0, e1, ew, cur_lock;
    logic [31:0] ea, ed, ep;
    #1;
    if (reset) {e0, e1} = 2'b00;
    else if (owner == 0) {e0, e1} = {m0_req, 1'b0};
    else if (owner == 1) {e0, e1} = {1'b0, m1_req};
    else if (m1_req && waited >= SL) {e0, e1} = 2'b01;
    else {e0, e1} = {m0_req, m1_req && !m0_req};
    ew = e0 ? m0_we : e1 ? m1_we : 1'b0;
    ea = e0 ? m0_addr : e1 ? m1_addr : 32'h0;
    ed = e0 ? m0_wdata : e1 ? m1_wdata : 32'h0;
    ep = e0 ? m0_pc : e1 ? m1_pc : 32'h0;
    chk("m0_gnt", {31'h0, m0_gnt}, {31'h0, e0});
    chk("m1_gnt", {31'h0, m1_gnt}, {31'h0, e1});
    chk("dm_we", {31'h0, dm_we}, {31'h0, ew});
    chk("dm_addr", dm_addr, ea);
    chk("dm_wdata", dm_wdata, ed);
    chk("dm_pc", dm_pc, ep);
    last_g1 = m1_gnt;
    pend0 = m0_req && !e0;
    pend1 = m1_req && !e1;
    if (reset) begin
      owner = -1; tenure = 0; waited = 0;
      exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = 0; exp_rd1 = 0;
    end else begin
      waited = (m1_req && !e1) ? ((waited < SL) ? waited + 1 : SL) : 0;
      exp_rv0 = e0 && !m0_we;
      exp_rv1 = e1 && !m1_we;
      if (exp_rv0) exp_rd0 = ref_mem[m0_addr[5:2]];
      if (exp_rv1) exp_rd1 = ref_mem[m1_addr[5:2]];
      if (ew) ref_mem[ea[5:2]] = ed;
      if (owner < 0) begin
        if ((e0 && m0_lock) || (e1 && m1_lock)) begin owner = e1 ? 1 : 0; tenure = 1; end
      end else begin
        cur_lock = (owner == 1) ? m1_lock : m0_lock;
        tenure++;
        if (!(e0 || e1) || !cur_lock || tenure >= ML) owner = -1;
      end
    end
    @(negedge clk);
    chk("m0_rvalid", {31'h0, m0_rvalid}, {31'h0, exp_rv0});
    chk("m1_rvalid", {31'h0, m1_rvalid}, {31'h0, exp_rv1});
    chk("m0_rdata", m0_rdata, exp_rd0);
    chk("m1_rdata", m1_rdata, exp_rd1);
  endtask

  task automatic idle();
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    {m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, m1_pc} = '0;
  endtask

  task automatic drive_rand(input int p0, input int p1);
    reset = $urandom_range(0, 99) == 0;
    if (!pend0) begin
      m0_req = $urandom_range(0, 99) < p0; m0_we = 1'($urandom); m0_lock = $urandom_range(0, 99) < 40;
      m0_addr = {26'h0, 4'($urandom), 2'b00}; m0_wdata = $urandom; m0_pc = $urandom;
    end
    if (!pend1) begin
      m1_req = $urandom_range(0, 99) < p1; m1_we = 1'($urandom); m1_lock = $urandom_range(0, 99) < 40;
      m1_addr = {26'h0, 4'($urandom), 2'b00}; m1_wdata = $urandom; m1_pc = $urandom;
    end
  endtask

  initial begin
    int first, cnt;
    idle();
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hdead_beef; m0_pc = 32'h400;
    step(); step();
    chk("t1_mem_untouched", mem[4], 32'h0);
    reset = 1'b0;
    step();
    chk("t1_mem_written", mem[4], 32'hdead_beef);
    idle(); m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h1234_5678;
    step();
    idle(); m1_req = 1'b1; m1_addr = 32'h10;
    step();
    chk("t2_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("t2_m1_rdata", m1_rdata, 32'h1234_5678);
    idle(); step();
    m0_req = 1'b1; m1_req = 1'b1; first = 0;
    for (int i = 1; i <= 6; i++) begin step(); if (last_g1 && first == 0) first = i; end
    chk("t3_starve_cycle", first, 5);
    idle(); step();
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h20; cnt = 0;
    step(); cnt += int'(last_g1);
    m0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); cnt += int'(last_g1); end
    chk("t4_m1_tenure", cnt, 3);
    idle(); step();
    m0_req = 1'b1; m1_req = 1'b1; first = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) m0_lock = 1'b1;
      step();
      if (last_g1 && first == 0) first = i;
    end
    chk("t5_after_lock", first, 7);
    idle(); step();
    m0_req = 1'b1; m0_addr = 32'h10;
    step();
    idle(); reset = 1'b1;
    step();
    chk("t6_rvalid_cleared", {31'h0, m0_rvalid}, 32'h0);
    reset = 1'b0; pend0 = 0; pend1 = 0;
    for (int i = 0; i < 3000; i++) begin
      drive_rand(((i / 300) % 2) ? 95 : 50, ((i / 150) % 2) ? 90 : 40);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-master arbiter sharing the single-port data memory between the pipeline MEM stage (master 0) and a secondary requester (master 1, debug/bridge port).
- Fixed priority to master 0.
- Starvation override for master 1.
- Bounded bus lock for read-modify-write sequences.
- Drives the data memory's address, write-data, write-enable and pc inputs; returns registered read data to the winning master.

Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles of m1 after which m1 wins the next arbitration in ST_IDLE.
- MAX_LOCK, 3: maximum consecutive granted accesses in one lock tenure.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; hold with payload stable until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_lock / m1_lock  in  1  request to retain ownership after this access
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_pc / m1_pc  in  32  pc of requesting instruction (trace only)
- m0_gnt / m1_gnt  out  1  combinational grant; the access completes at this clock edge
- m0_rvalid / m1_rvalid  out  1  read data valid, one cycle after a granted read
- m0_rdata / m1_rdata  out  32  registered read data
- dm_addr  out  32  to memory address
- dm_wdata  out  32  to memory write data
- dm_pc  out  32  to memory pc
- dm_we  out  1  to memory write enable
- dm_rdata  in  32  memory combinational read data

Behaviour:
- At most one grant per cycle; throughput is one access per cycle.
- No grant: dm_we=0, dm_addr=0, dm_wdata=0, dm_pc=0. Grant: dm_* mirror the granted master's payload combinationally.
- Grant is combinational in the request cycle.
  - Write: committed by memory at that posedge.
  - Read: dm_rdata captured into mX_rdata at that posedge; mX_rvalid=1 for exactly the next cycle.
  - rdata holds its value until the next granted read by the same master.
- States:
  - ST_IDLE: if m1_req && wait_cnt==STARVE_LIMIT, grant m1; else if m0_req, grant m0; else if m1_req, grant m1.
  - ST_LOCK0: only m0 may be granted; m1 is blocked.
  - ST_LOCK1: only m1 may be granted; m0 is blocked, including the pipeline.
- Transitions:
  - Granted master with lock=1 in ST_IDLE: enter ST_LOCKx, lock_cnt=1.
  - In ST_LOCKx, a granted access with lock=1 and lock_cnt<MAX_LOCK-1 increments lock_cnt and stays.
  - In ST_LOCKx, return to ST_IDLE when any of these holds: owner has lock=0, owner drops req, or lock_cnt reaches MAX_LOCK-1 on a granted access. The access in that cycle is still served.
  - Max tenure is therefore MAX_LOCK accesses.
- wait_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments when m1_req && !m1_gnt, saturating at STARVE_LIMIT.
  - Clears when m1_gnt or !m1_req.
  - Counts during ST_LOCK0 as well.
- Override applies only in ST_IDLE; it never breaks an active lock.
- Simultaneous requests in ST_IDLE with wait_cnt<STARVE_LIMIT: m0 wins.
- Reset (synchronous):
  - state=ST_IDLE, wait_cnt=0, lock_cnt=0, rvalid=0, rdata=0.
  - Grants and dm_we are forced 0 while reset=1, so no memory write can occur during reset.
  - A reset mid-lock abandons the tenure.
  - A pending rvalid is cleared.

Optional Feature:
ARB_TRACE_EN
- Defined: each granted write prints "%d@%h: *%h <= %h" ($time, pc, addr, wdata), the same format as the memory trace, prefixed "M0 " or "M1 ".
- Undefined: no simulation output; RTL is otherwise identical.

Decomposition:
- Package dm_arb_pkg holds:
  - state encodings ST_IDLE / ST_LOCK0 / ST_LOCK1 (2-bit)
  - master IDs MST0=0, MST1=1
  - width function for wait_cnt
- Natural sub-module: dm_arb_starve_cnt, the saturating wait counter with inc/clr/sat outputs, parameterised by STARVE_LIMIT.
- Datapath muxing and FSM stay in dm_arbiter.

Test Plan:
1. Reset for 2 cycles while m0_req=1, m0_we=1 -> no gnt, dm_we=0; memory word unchanged; after release, first cycle grants m0.
2. m0 writes 0x1234_5678 to 0x10; next cycle m1 reads 0x10 -> m1_gnt in cycle 2, m1_rvalid=1 in cycle 3 with m1_rdata=0x1234_5678.
3. m0_req and m1_req held high, STARVE_LIMIT=4 -> m0 granted cycles 1–4, m1 granted cycle 5, wait_cnt returns to 0.
4. m1 lock=1 for 5 requests, MAX_LOCK=3, m0_req high -> m1 granted cycles 1–3, m0 granted cycle 4, state ST_IDLE after cycle 3.
5. m0 lock tenure in progress while m1 wait_cnt saturates -> m1 is not granted until m0 releases, then m1 wins immediately.
6. Reset asserted in cycle after a granted read -> m0_rvalid=0 next cycle, state ST_IDLE.
